ins_fetch_queue: RTL and testbench

INS_FETCH_QUEUE -- requirements
Module: ins_fetch_queue

---
 rtl/ins_fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_ins_fetch_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ins_fetch_queue
// Purpose  : Instruction prefetch unit. Issues word-aligned requests to the
//            instruction memory and buffers returned words, together with
//            their fetch addresses, in a small FIFO feeding decode. Branch
//            redirects flush the FIFO. A request that is in flight during a
//            redirect is still completed on the bus, but its data is dropped.
// Ports    : clk_i          - clock, rising edge
//            reset_i        - synchronous active-high reset
//            redirect_i     - flush and refetch from redirect_pc_i
//            redirect_pc_i  - new fetch address (bits [1:0] ignored)
//            imem_req_o     - memory request, held until imem_ack_i
//            imem_addr_o    - request address, stable while imem_req_o = 1
//            imem_ack_i     - imem_data_i is valid for the current request
//            imem_data_i    - returned instruction word
//            ins_valid_o    - queue head is valid
//            ins_out_o      - head instruction (0 when not valid)
//            ins_pc_o       - head fetch address (0 when not valid)
//            ins_ready_i    - decode consumes the head this cycle
//            queue_count_o  - number of valid queue entries
// Revision : 1.0 - initial release
// ============================================================================
module ins_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_data_i,
    output logic                       ins_valid_o,
    output logic [31:0]                ins_out_o,
    output logic [31:0]                ins_pc_o,
    input  logic                       ins_ready_i,
    output logic [$clog2(DEPTH):0]     queue_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;   // nothing outstanding
    localparam logic [1:0] S_WAIT    = 2'd1;   // outstanding, data kept
    localparam logic [1:0] S_DISCARD = 2'd2;   // outstanding, data dropped

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   imem_addr_q, imem_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_after;
    logic          w_room_after;

    // Redirect wins over both queue operations.
    assign w_push        = (state_q == S_WAIT) && imem_ack_i && !redirect_i;
    assign w_pop         = (count_q != '0) && ins_ready_i && !redirect_i;
    // Never overflows: a slot is reserved when the request is issued.
    assign w_count_after = count_q + CW'(w_push) - CW'(w_pop);
    assign w_room_after  = (w_count_after < CW'(DEPTH));

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_addr_q <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_addr_q <= imem_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (!reset_i && w_push) begin
            data_q[wr_ptr_q] <= imem_data_i;
            pc_q[wr_ptr_q]   <= imem_addr_q;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!redirect_i && (count_q < CW'(DEPTH))) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack_i) begin
                    // Back-to-back issue only for a kept word with room left.
                    state_d = (w_push && w_room_after) ? S_WAIT : S_IDLE;
                end else if (redirect_i) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        imem_addr_d = imem_addr_q;
        count_d     = w_count_after;
        rd_ptr_d    = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d    = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else if (w_push) begin
            fetch_pc_d = imem_addr_q + 32'd4;
        end

        // The address only moves when a new request starts; it is frozen
        // for the whole handshake, including the discard case.
        if ((state_q == S_IDLE) && (state_d == S_WAIT)) begin
            imem_addr_d = fetch_pc_q;
        end else if (w_push && (state_d == S_WAIT)) begin
            imem_addr_d = imem_addr_q + 32'd4;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all derived from registers only)
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_o    = (state_q == S_WAIT) || (state_q == S_DISCARD);
        imem_addr_o   = imem_addr_q;
        ins_valid_o   = (count_q != '0);
        ins_out_o     = ins_valid_o ? data_q[rd_ptr_q] : 32'd0;
        ins_pc_o      = ins_valid_o ? pc_q[rd_ptr_q]   : 32'd0;
        queue_count_o = count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_fetch_queue
// Purpose  : Self-checking bench for ins_fetch_queue: directed scenarios
//            followed by randomized traffic, compared every cycle against a
//            queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic [2:0]  queue_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model: FIFO of {pc, data}, one in-flight request flag,
    // a drop flag for redirected requests, and the next fetch address.
    logic [63:0] m_q [$];
    logic        m_busy;
    logic        m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_fetch;

    ins_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .ins_valid_o   (ins_valid),
        .ins_out_o     (ins_out),
        .ins_pc_o      (ins_pc),
        .ins_ready_i   (ins_ready),
        .queue_count_o (queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int   n0;
        logic pop;
        if (reset) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_drop  = 1'b0;
            m_addr  = 32'd0;
            m_fetch = RESET_PC;
            return;
        end
        n0  = m_q.size();
        pop = (n0 > 0) && ins_ready && !redirect;
        if (redirect) begin
            m_q.delete();
            m_fetch = redirect_pc & 32'hFFFF_FFFC;
            if (m_busy) begin
                if (imem_ack) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_busy) begin
                if (imem_ack) begin
                    if (m_drop) begin
                        m_busy = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        m_q.push_back({m_addr, imem_data});
                        m_fetch = m_addr + 32'd4;
                        if (m_q.size() < DEPTH) m_addr = m_addr + 32'd4;
                        else                    m_busy = 1'b0;
                    end
                end
            end else if (n0 < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_fetch;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 64'd0;
        chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, m_busy});
        chk({tag, ".addr"},  imem_addr,            m_addr);
        chk({tag, ".valid"}, {31'd0, ins_valid},   (m_q.size() > 0) ? 32'd1 : 32'd0);
        chk({tag, ".out"},   ins_out,              h[31:0]);
        chk({tag, ".pc"},    ins_pc,               h[63:32]);
        chk({tag, ".count"}, {29'd0, queue_count}, m_q.size());
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic step(input string tag, input logic r, input logic rd,
                        input logic [31:0] rpc, input logic a,
                        input logic [31:0] d, input logic rdy);
        reset       = r;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = a;
        imem_data   = d;
        ins_ready   = rdy;
        @(posedge clk);
        model_update();
        #1;
        check_model(tag);
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_data = 32'd0; ins_ready = 1'b0;

        // Reset state
        step("reset", 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        step("reset", 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1);
        chk("reset_count", {29'd0, queue_count}, 32'd0);

        // Streaming: one instruction per cycle after two-cycle startup
        for (int i = 1; i <= 6; i++) begin
            step("stream", 1'b0, 1'b0, 32'd0, 1'b1, $urandom, 1'b1);
            if (i == 1) chk("stream_req", {31'd0, imem_req}, 32'd1);
            if (i >= 2) chk("stream_pc", ins_pc, 32'((i - 2) * 4));
        end

        // Fill with decode stalled: queue stops at DEPTH, request drops
        for (int i = 0; i < 8; i++)
            step("fill", 1'b0, 1'b0, 32'd0, 1'b1, $urandom, 1'b0);
        chk("fill_count", {29'd0, queue_count}, 32'd4);
        chk("fill_req", {31'd0, imem_req}, 32'd0);
        step("pulse", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        step("pulse", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("pulse_req", {31'd0, imem_req}, 32'd1);
        step("pulse", 1'b0, 1'b0, 32'd0, 1'b1, 32'hC0DE_0001, 1'b0);
        chk("pulse_count", {29'd0, queue_count}, 32'd4);
        chk("pulse_req_off", {31'd0, imem_req}, 32'd0);

        // Delayed ack on 0x8: request held stable for four cycles
        step("redir8", 1'b0, 1'b1, 32'h8, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("slow", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            chk("slow_addr", imem_addr, 32'h8);
        end
        step("slow_ack", 1'b0, 1'b0, 32'd0, 1'b1, 32'hABCD_0008, 1'b0);
        chk("slow_count", {29'd0, queue_count}, 32'd1);
        step("slow_ack", 1'b0, 1'b0, 32'd0, 1'b1, 32'hABCD_000C, 1'b0);

        // Redirect while waiting on 0x10: data discarded
        step("disc", 1'b0, 1'b1, 32'h103, 1'b0, 32'd0, 1'b0);
        chk("disc_addr", imem_addr, 32'h10);
        chk("disc_count", {29'd0, queue_count}, 32'd0);
        step("disc_ack", 1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("disc_valid", {31'd0, ins_valid}, 32'd0);
        step("disc_new", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("disc_addr2", imem_addr, 32'h100);

        // Address wrap at the top of memory
        step("wrap", 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1);
        step("wrap", 1'b0, 1'b0, 32'd0, 1'b1, 32'h1111_1111, 1'b1);
        step("wrap", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
        step("wrap", 1'b0, 1'b0, 32'd0, 1'b1, 32'h2222_2222, 1'b1);
        chk("wrap_addr_lo", imem_addr, 32'h0);

        // Reset during a request; ack right after it is ignored
        step("rst_wait", 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        step("rst_ack", 1'b0, 1'b0, 32'd0, 1'b1, 32'h5555_AAAA, 1'b0);
        chk("rst_ack_count", {29'd0, queue_count}, 32'd0);
        chk("rst_ack_addr", imem_addr, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step("rand",
                 ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 19) == 0),
                 $urandom,
                 m_busy && ($urandom_range(0, 2) != 0),
                 $urandom,
                 ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
